l2_req_arb: RTL and testbench
=============================

L2_REQ_ARB -- requirements
Module: l2_req_arb

Interface
REQ-001 SHALL have parameter QDEPTH, default 4: maximum number of read-type requests outstanding awaiting response; power of two, 2..8.
REQ-002 SHALL have port `clk`, input, 1 bit: the only clock.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports `req0_valid`/`req1_valid`, input, 1 bit each: requester 0 (dcache) / requester 1 (icache) request valid.
REQ-005 SHALL have ports `req0_op`/`req1_op`, input, 2 bits: `OP_*` encoding; bit 0 set = read-type.
REQ-006 SHALL have ports `req0_addr`/`req1_addr`, input, [31:3]: request address.
REQ-007 SHALL have ports `req0_wmask`/`req1_wmask`, input, 8 bits, and `req0_wdata`/`req1_wdata`, input, 64 bits: write mask and data for the beat.
REQ-008 SHALL have ports `req0_ready`/`req1_ready`, output, 1 bit: beat accepted from that requester.
REQ-009 SHALL have outputs `l2_req_valid` (1), `l2_req_op` (2), `l2_req_addr` ([31:3]), `l2_req_wmask` (8), `l2_req_wdata` (64), and input `l2_req_ready` (1): merged request to the L2.
REQ-010 SHALL have inputs `l2_resp_valid` (1), `l2_resp_error` (1), `l2_resp_op` (2), `l2_resp_addr` ([31:6]), `l2_resp_rdata` (64), and output `resp_ready` (1): L2 response stream.
REQ-011 SHALL have per-port outputs `resp0_valid`/`resp1_valid` (1), `resp0_error`/`resp1_error` (1), `resp0_op`/`resp1_op` (2), `resp0_addr`/`resp1_addr` ([31:6]), `resp0_rdata`/`resp1_rdata` (64), and inputs `resp0_ready`/`resp1_ready` (1).
REQ-012 SHALL have output `arb_idle`, 1 bit: no lock held and tag queue empty.

Function
REQ-013 SHALL pass the request fields of the granted port combinationally to `l2_req_*`, with `l2_req_valid` = granted `reqN_valid` & ~block, and `reqN_ready` = granted & `l2_req_ready` & ~block.
REQ-014 SHALL grant by round-robin when unlocked: the last port that completed a handshake loses a tie; after reset port 0 has priority.
REQ-015 SHALL block a read-type request while the tag queue holds QDEPTH entries, even if a pop occurs the same cycle; a blocked port SHALL NOT cause the grant to move to the other port within that cycle.
REQ-016 SHALL, on an accepted `OP_WR64` first beat, lock the grant to that port until 7 further beats are accepted; during the lock, field changes other than `wmask`/`wdata` are ignored, the beat counter wraps to 0, and the lock releases after the 8th beat.
REQ-017 SHALL push the granted port ID into an in-order tag queue on each accepted read-type request, with latency 0 and no address dependence.
REQ-018 SHALL route each response beat to the port at the queue head: `respN_valid` = `l2_resp_valid` & head==N & queue nonempty; `resp_ready` = `respN_ready` of the head port.
REQ-019 SHALL count response handshakes 0..7 with a 3-bit counter, and pop the queue on the 8th beat.
REQ-020 SHALL allow push and pop in the same cycle, leaving the occupancy unchanged.
REQ-021 SHALL, for `l2_resp_valid` with an empty queue, hold `resp_ready`=0, keep all `respN_valid` at 0, and set sticky internal flag `resp_orphan_r` (not cleared except by reset).

Reset
REQ-022 SHALL, on `rst`, clear the tag queue and its pointers, beat counters, lock and `resp_orphan_r`, and set round-robin priority to port 0; on the next cycle `reqN_ready`=0, `l2_req_valid`=0, `respN_valid`=0, `resp_ready`=0 and `arb_idle`=1.
REQ-023 SHALL, on reset mid-burst or mid-response, discard partial state with no completion signalled.

Configuration
REQ-024 SHALL, when `L2ARB_FIXED_PRIO_EN` is defined, use fixed priority (port 0 always wins ties) and remove the round-robin state.
REQ-025 SHALL, when `L2ARB_FIXED_PRIO_EN` is undefined, use round-robin per REQ-014; locking and queueing are identical in both builds.

Verification
REQ-026 SHALL cover: both ports assert an `OP_RD` every cycle with `l2_req_ready`=1 -> grants alternate 0,1,0,1; queue fills at 4, then both `reqN_ready`=0 until a pop.
REQ-027 SHALL cover: port 1 issues `OP_WR64` while port 0 holds `OP_RD` valid -> 8 consecutive port-1 beats, `wdata` 0..7 forwarded in order, then port 0 granted.
REQ-028 SHALL cover: reads from ports 0, 1, 0, then 24 response beats with `respN_ready`=1 -> beats 1-8 to port 0, 9-16 to port 1, 17-24 to port 0; `arb_idle`=1 afterward.
REQ-029 SHALL cover: `resp0_ready` deasserted at beat 3 for 5 cycles -> `resp_ready`=0, beat counter holds at 3, no pop.
REQ-030 SHALL cover: `rst` asserted after beat 4 of a `OP_WR64` burst -> next cycle lock cleared, `arb_idle`=1, and a fresh port-0 `OP_RD` granted immediately.
REQ-031 SHALL cover: queue full, final response beat and new read in the same cycle -> pop occurs, push blocked, read accepted on the following cycle.

Source files
------------

// File: rtl/l2_req_arb_if.sv
// l2_req_arb_if: bundle of the two requester ports, the merged L2 request,
// the L2 response stream and the per-port response outputs.
// slave modport = arbiter side, master modport = environment side.
interface l2_req_arb_if;
  logic        req0_valid;
  logic [1:0]  req0_op;
  logic [31:3] req0_addr;
  logic [7:0]  req0_wmask;
  logic [63:0] req0_wdata;
  logic        req0_ready;

  logic        req1_valid;
  logic [1:0]  req1_op;
  logic [31:3] req1_addr;
  logic [7:0]  req1_wmask;
  logic [63:0] req1_wdata;
  logic        req1_ready;

  logic        l2_req_valid;
  logic [1:0]  l2_req_op;
  logic [31:3] l2_req_addr;
  logic [7:0]  l2_req_wmask;
  logic [63:0] l2_req_wdata;
  logic        l2_req_ready;

  logic        l2_resp_valid;
  logic        l2_resp_error;
  logic [1:0]  l2_resp_op;
  logic [31:6] l2_resp_addr;
  logic [63:0] l2_resp_rdata;
  logic        resp_ready;

  logic        resp0_valid;
  logic        resp0_error;
  logic [1:0]  resp0_op;
  logic [31:6] resp0_addr;
  logic [63:0] resp0_rdata;
  logic        resp0_ready;

  logic        resp1_valid;
  logic        resp1_error;
  logic [1:0]  resp1_op;
  logic [31:6] resp1_addr;
  logic [63:0] resp1_rdata;
  logic        resp1_ready;

  logic        arb_idle;
  logic        resp_orphan;

  modport slave (
    input  req0_valid, req0_op, req0_addr, req0_wmask, req0_wdata,
    input  req1_valid, req1_op, req1_addr, req1_wmask, req1_wdata,
    output req0_ready, req1_ready,
    output l2_req_valid, l2_req_op, l2_req_addr, l2_req_wmask, l2_req_wdata,
    input  l2_req_ready,
    input  l2_resp_valid, l2_resp_error, l2_resp_op, l2_resp_addr, l2_resp_rdata,
    output resp_ready,
    output resp0_valid, resp0_error, resp0_op, resp0_addr, resp0_rdata,
    input  resp0_ready,
    output resp1_valid, resp1_error, resp1_op, resp1_addr, resp1_rdata,
    input  resp1_ready,
    output arb_idle, resp_orphan
  );

  modport master (
    output req0_valid, req0_op, req0_addr, req0_wmask, req0_wdata,
    output req1_valid, req1_op, req1_addr, req1_wmask, req1_wdata,
    input  req0_ready, req1_ready,
    input  l2_req_valid, l2_req_op, l2_req_addr, l2_req_wmask, l2_req_wdata,
    output l2_req_ready,
    output l2_resp_valid, l2_resp_error, l2_resp_op, l2_resp_addr, l2_resp_rdata,
    input  resp_ready,
    input  resp0_valid, resp0_error, resp0_op, resp0_addr, resp0_rdata,
    output resp0_ready,
    input  resp1_valid, resp1_error, resp1_op, resp1_addr, resp1_rdata,
    output resp1_ready,
    input  arb_idle, resp_orphan
  );
endinterface

// File: rtl/l2_req_arb.sv
// l2_req_arb: merges dcache (port 0) and icache (port 1) requests onto one
// L2 request channel, locks the grant for 8-beat OP_WR64 bursts, and routes
// 8-beat read responses back through an in-order tag queue.
// Build option: define L2ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// ties); default build is round-robin.
module l2_req_arb #(
  parameter int unsigned QDEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  l2_req_arb_if.slave bus
);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [1:0]  OP_WR64 = 2'b10;

  typedef enum logic {ST_OPEN, ST_LOCK} state_t;

  state_t      state;
  logic        lock_port;
  logic [1:0]  lock_op;
  logic [31:3] lock_addr;
  logic [2:0]  wr_cnt;

  logic        prio;
  logic        grant;

  logic [QDEPTH-1:0] tagq;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [2:0]        rsp_cnt;
  logic              resp_orphan_r;

  logic        sel_valid;
  logic [1:0]  sel_op;
  logic [31:3] sel_addr;
  logic [7:0]  sel_wmask;
  logic [63:0] sel_wdata;
  logic        full;
  logic        block;
  logic        req_ok;
  logic        req_hs;
  logic        push;
  logic        q_nonempty;
  logic        head;
  logic        rsp_hs;
  logic        pop;

  // Grant: held by the lock owner, otherwise the only valid port, otherwise
  // the priority port. Blocking never feeds back into this choice.
  always_comb begin
    grant = prio;
    if (state == ST_LOCK)
      grant = lock_port;
    else if (bus.req0_valid && !bus.req1_valid)
      grant = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid)
      grant = 1'b1;
  end

  // Field mux for the granted port; op/addr frozen while a burst is locked.
  always_comb begin
    sel_valid = bus.req0_valid;
    sel_op    = bus.req0_op;
    sel_addr  = bus.req0_addr;
    sel_wmask = bus.req0_wmask;
    sel_wdata = bus.req0_wdata;
    if (grant) begin
      sel_valid = bus.req1_valid;
      sel_op    = bus.req1_op;
      sel_addr  = bus.req1_addr;
      sel_wmask = bus.req1_wmask;
      sel_wdata = bus.req1_wdata;
    end
    if (state == ST_LOCK) begin
      sel_op   = lock_op;
      sel_addr = lock_addr;
    end
  end

  // A full queue blocks reads even when a pop lands in the same cycle.
  assign full   = (count == CW'(QDEPTH));
  assign block  = sel_op[0] & full;
  assign req_ok = bus.l2_req_ready & ~block & ~rst;

  assign bus.l2_req_valid = sel_valid & ~block & ~rst;
  assign bus.l2_req_op    = sel_op;
  assign bus.l2_req_addr  = sel_addr;
  assign bus.l2_req_wmask = sel_wmask;
  assign bus.l2_req_wdata = sel_wdata;
  assign bus.req0_ready   = ~grant & req_ok;
  assign bus.req1_ready   = grant & req_ok;

  assign req_hs = bus.l2_req_valid & bus.l2_req_ready;
  assign push   = req_hs & sel_op[0];

  // Response routing follows the port ID at the queue head.
  assign q_nonempty = (count != '0);
  assign head       = tagq[rd_ptr];

  assign bus.resp_ready  = q_nonempty & ~rst & (head ? bus.resp1_ready : bus.resp0_ready);
  assign bus.resp0_valid = bus.l2_resp_valid & q_nonempty & ~head & ~rst;
  assign bus.resp1_valid = bus.l2_resp_valid & q_nonempty & head & ~rst;
  assign bus.resp0_error = bus.l2_resp_error;
  assign bus.resp1_error = bus.l2_resp_error;
  assign bus.resp0_op    = bus.l2_resp_op;
  assign bus.resp1_op    = bus.l2_resp_op;
  assign bus.resp0_addr  = bus.l2_resp_addr;
  assign bus.resp1_addr  = bus.l2_resp_addr;
  assign bus.resp0_rdata = bus.l2_resp_rdata;
  assign bus.resp1_rdata = bus.l2_resp_rdata;

  assign rsp_hs = bus.l2_resp_valid & bus.resp_ready;
  assign pop    = rsp_hs & (rsp_cnt == 3'd7);

  assign bus.arb_idle    = (state == ST_OPEN) & ~q_nonempty;
  assign bus.resp_orphan = resp_orphan_r;

  // Burst lock FSM: first OP_WR64 beat locks, 8th beat releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OPEN;
      lock_port <= 1'b0;
      lock_op   <= 2'b00;
      lock_addr <= '0;
      wr_cnt    <= 3'd0;
    end else begin
      case (state)
        ST_OPEN: begin
          if (req_hs && sel_op == OP_WR64) begin
            state     <= ST_LOCK;
            lock_port <= grant;
            lock_op   <= sel_op;
            lock_addr <= sel_addr;
            wr_cnt    <= 3'd1;
          end
        end
        ST_LOCK: begin
          if (req_hs) begin
            wr_cnt <= wr_cnt + 3'd1;
            if (wr_cnt == 3'd7)
              state <= ST_OPEN;
          end
        end
        default: state <= ST_OPEN;
      endcase
    end
  end

`ifdef L2ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  // Round-robin: the port that just completed a handshake yields the tie.
  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (req_hs)
      prio <= ~grant;
  end
`endif

  // In-order tag queue of requester IDs for outstanding reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagq   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tagq[wr_ptr] <= grant;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Response beat counter and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_cnt       <= 3'd0;
      resp_orphan_r <= 1'b0;
    end else begin
      if (rsp_hs)
        rsp_cnt <= rsp_cnt + 3'd1;
      if (bus.l2_resp_valid && !q_nonempty)
        resp_orphan_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l2_req_arb.sv
// tb_l2_req_arb: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the arbiter.
module tb_l2_req_arb;
  localparam int unsigned QDEPTH = 4;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_WR64 = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_req_arb_if bus ();
  l2_req_arb #(.QDEPTH(QDEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit          m_q[$];
  bit          m_prio;
  int          m_lock_left;
  bit          m_lock_port;
  logic [1:0]  m_lock_op;
  logic [31:3] m_lock_addr;
  int          m_beats;
  bit          m_orphan;

  // Compare DUT outputs against the model, then advance the model by the
  // transfers that the coming clock edge will complete.
  always @(negedge clk) begin : mdl
    logic g, vg, blk, ev, hs, ne, hd, er, e0, e1;
    logic [1:0]  op;
    logic [31:3] addr;
    if (chk_en) begin
      if (m_lock_left > 0) g = m_lock_port;
      else if (bus.req0_valid && bus.req1_valid) g = m_prio;
      else if (bus.req1_valid) g = 1'b1;
      else if (bus.req0_valid) g = 1'b0;
      else g = m_prio;
      vg   = g ? bus.req1_valid : bus.req0_valid;
      op   = (m_lock_left > 0) ? m_lock_op : (g ? bus.req1_op : bus.req0_op);
      addr = (m_lock_left > 0) ? m_lock_addr : (g ? bus.req1_addr : bus.req0_addr);
      blk  = op[0] && (m_q.size() == QDEPTH);
      ev   = vg && !blk && !rst;
      hs   = ev && bus.l2_req_ready;
      chk("m_l2_valid", 64'(bus.l2_req_valid), 64'(ev));
      if (ev) begin
        chk("m_l2_op", 64'(bus.l2_req_op), 64'(op));
        chk("m_l2_addr", 64'(bus.l2_req_addr), 64'(addr));
        chk("m_l2_wmask", 64'(bus.l2_req_wmask), 64'(g ? bus.req1_wmask : bus.req0_wmask));
        chk("m_l2_wdata", bus.l2_req_wdata, g ? bus.req1_wdata : bus.req0_wdata);
      end
      if (bus.req0_valid)
        chk("m_req0_ready", 64'(bus.req0_ready), 64'(!g && bus.l2_req_ready && !blk && !rst));
      if (bus.req1_valid)
        chk("m_req1_ready", 64'(bus.req1_ready), 64'(g && bus.l2_req_ready && !blk && !rst));
      ne = (m_q.size() > 0);
      hd = ne ? m_q[0] : 1'b0;
      er = ne && !rst && (hd ? bus.resp1_ready : bus.resp0_ready);
      e0 = bus.l2_resp_valid && ne && !hd && !rst;
      e1 = bus.l2_resp_valid && ne && hd && !rst;
      chk("m_resp_ready", 64'(bus.resp_ready), 64'(er));
      chk("m_resp0_valid", 64'(bus.resp0_valid), 64'(e0));
      chk("m_resp1_valid", 64'(bus.resp1_valid), 64'(e1));
      if (e0) chk("m_resp0_data", bus.resp0_rdata ^ 64'(bus.resp0_addr) ^ 64'({bus.resp0_error, bus.resp0_op}),
                  bus.l2_resp_rdata ^ 64'(bus.l2_resp_addr) ^ 64'({bus.l2_resp_error, bus.l2_resp_op}));
      if (e1) chk("m_resp1_data", bus.resp1_rdata ^ 64'(bus.resp1_addr) ^ 64'({bus.resp1_error, bus.resp1_op}),
                  bus.l2_resp_rdata ^ 64'(bus.l2_resp_addr) ^ 64'({bus.l2_resp_error, bus.l2_resp_op}));
      chk("m_arb_idle", 64'(bus.arb_idle), 64'(m_lock_left == 0 && m_q.size() == 0));
      chk("m_orphan", 64'(bus.resp_orphan), 64'(m_orphan));
      if (rst) begin
        m_q.delete();
        m_prio = 1'b0; m_lock_left = 0; m_beats = 0; m_orphan = 1'b0;
      end else begin
        if (bus.l2_resp_valid && !ne) m_orphan = 1'b1;
        if (bus.l2_resp_valid && er) begin
          m_beats++;
          if (m_beats == 8) begin
            m_beats = 0;
            void'(m_q.pop_front());
          end
        end
        if (hs) begin
`ifndef L2ARB_FIXED_PRIO_EN
          m_prio = !g;
`endif
          if (m_lock_left > 0) m_lock_left--;
          else if (op == OP_WR64) begin
            m_lock_left = 7; m_lock_port = g; m_lock_op = op; m_lock_addr = addr;
          end
          if (op[0]) m_q.push_back(g);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = OP_WR; bus.req0_addr = '0; bus.req0_wmask = '0; bus.req0_wdata = '0;
    bus.req1_valid = 0; bus.req1_op = OP_WR; bus.req1_addr = '0; bus.req1_wmask = '0; bus.req1_wdata = '0;
    bus.l2_req_ready = 0;
    bus.l2_resp_valid = 0; bus.l2_resp_error = 0; bus.l2_resp_op = '0; bus.l2_resp_addr = '0; bus.l2_resp_rdata = '0;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
  endtask

  // Present response beats until n handshakes have been seen (bounded).
  task automatic drain(input int n);
    int got = 0;
    bus.l2_resp_valid = 1;
    for (int c = 0; c < 400 && got < n; c++) begin
      bus.resp0_ready   = ($urandom_range(0, 3) != 0);
      bus.resp1_ready   = ($urandom_range(0, 3) != 0);
      bus.l2_resp_rdata = {$urandom, $urandom};
      bus.l2_resp_addr  = 26'($urandom);
      bus.l2_resp_op    = 2'($urandom);
      bus.l2_resp_error = 1'($urandom);
      @(negedge clk);
      if (bus.l2_resp_valid && bus.resp_ready) got++;
      step();
    end
    bus.l2_resp_valid = 0; bus.resp0_ready = 1; bus.resp1_ready = 1;
    chk("drain_beats", 64'(got), 64'(n));
  endtask

  initial begin
    int beat, stall;
    bit stalled, port;
    idle_inputs();
    // Reset: outputs gated while rst is high, idle after
    bus.req0_valid = 1; bus.req0_op = OP_RD; bus.l2_req_ready = 1;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_l2_valid", 64'(bus.l2_req_valid), 64'd0);
    chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    step();
    rst = 0; idle_inputs();
    @(negedge clk);
    chk("rst_idle", 64'(bus.arb_idle), 64'd1);
    chk("rst_resp_ready", 64'(bus.resp_ready), 64'd0);
    chk("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
    step();

    // Both ports read every cycle: alternate grants, queue fills at QDEPTH
    bus.req0_valid = 1; bus.req0_op = OP_RD; bus.req0_addr = 29'h100;
    bus.req1_valid = 1; bus.req1_op = OP_RD; bus.req1_addr = 29'h200;
    bus.l2_req_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef L2ARB_FIXED_PRIO_EN
      chk("a_grant0", 64'(bus.req0_ready), 64'(k < 4));
      chk("a_grant1", 64'(bus.req1_ready), 64'd0);
`else
      chk("a_grant0", 64'(bus.req0_ready), 64'(k < 4 && k % 2 == 0));
      chk("a_grant1", 64'(bus.req1_ready), 64'(k < 4 && k % 2 == 1));
`endif
      step();
    end
    // 8 response beats; push stays blocked through the popping beat
    bus.l2_resp_valid = 1;
    for (int b = 0; b < 8; b++) begin
      bus.l2_resp_rdata = 64'(b);
      @(negedge clk);
      chk("a_resp0_valid", 64'(bus.resp0_valid), 64'd1);
      chk("a_blocked", 64'(bus.l2_req_valid), 64'd0);
      step();
    end
    bus.l2_resp_valid = 0;
    @(negedge clk);
    chk("a_after_pop", 64'(bus.req0_ready), 64'd1);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain(32);
    @(negedge clk);
    chk("a_idle", 64'(bus.arb_idle), 64'd1);
    step();

    // Port 1 WR64 burst while port 0 waits with a read
    bus.req1_valid = 1; bus.req1_op = OP_WR64; bus.req1_addr = 29'h0abc; bus.req1_wdata = 0; bus.req1_wmask = 8'hff;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b_req1_ready", 64'(bus.req1_ready), 64'd1);
      chk("b_op", 64'(bus.l2_req_op), 64'(OP_WR64));
      chk("b_addr", 64'(bus.l2_req_addr), 64'h0abc);
      chk("b_wdata", bus.l2_req_wdata, 64'(i));
      step();
      bus.req1_wdata = 64'(i + 1); bus.req1_addr = 29'($urandom); bus.req1_op = OP_RD;
      bus.req1_wmask = 8'($urandom);
      bus.req0_valid = 1; bus.req0_op = OP_RD; bus.req0_addr = 29'h300;
    end
    @(negedge clk);
    chk("b_port0_next", 64'(bus.req0_ready), 64'd1);
    chk("b_port1_wait", 64'(bus.req1_ready), 64'd0);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain(8);

    // Reads 0,1,0 then 24 beats with a 5-cycle port-0 stall at beat 3
    for (int i = 0; i < 3; i++) begin
      bus.req0_valid = (i != 1); bus.req1_valid = (i == 1);
      bus.req0_op = OP_RD; bus.req1_op = OP_RD;
      @(negedge clk);
      chk("c_issue", 64'(i == 1 ? bus.req1_ready : bus.req0_ready), 64'd1);
      step();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    beat = 0; stall = 0; stalled = 0;
    bus.l2_resp_valid = 1; bus.resp0_ready = 1; bus.resp1_ready = 1;
    for (int c = 0; c < 80 && beat < 24; c++) begin
      bus.l2_resp_rdata = 64'(beat);
      @(negedge clk);
      port = (beat >= 8 && beat < 16);
      chk("c_route0", 64'(bus.resp0_valid), 64'(!port));
      chk("c_route1", 64'(bus.resp1_valid), 64'(port));
      chk(stall > 0 ? "c_stall" : "c_ready", 64'(bus.resp_ready), 64'(stall == 0));
      if (bus.resp_ready) beat++;
      step();
      if (stall > 0) begin
        stall--;
        if (stall == 0) bus.resp0_ready = 1;
      end else if (beat == 2 && !stalled) begin
        stalled = 1; stall = 5; bus.resp0_ready = 0;
      end
    end
    bus.l2_resp_valid = 0;
    chk("c_beats", 64'(beat), 64'd24);
    @(negedge clk);
    chk("c_idle", 64'(bus.arb_idle), 64'd1);
    step();

    // Reset after beat 4 of a port-0 WR64 burst
    bus.req0_valid = 1; bus.req0_op = OP_WR64; bus.req0_addr = 29'h555;
    for (int i = 0; i < 4; i++) begin
      bus.req0_wdata = 64'(i);
      @(negedge clk);
      chk("d_beat", 64'(bus.req0_ready), 64'd1);
      step();
    end
    rst = 1; bus.req0_op = OP_RD; bus.req0_addr = 29'h777;
    @(negedge clk);
    chk("d_rst_gate", 64'(bus.l2_req_valid), 64'd0);
    step();
    rst = 0;
    @(negedge clk);
    chk("d_idle", 64'(bus.arb_idle), 64'd1);
    chk("d_grant", 64'(bus.req0_ready), 64'd1);
    chk("d_op", 64'(bus.l2_req_op), 64'(OP_RD));
    chk("d_addr", 64'(bus.l2_req_addr), 64'h777);
    step();
    bus.req0_valid = 0;
    drain(8);

    // Response with empty queue: dropped and flagged until reset
    bus.l2_resp_valid = 1;
    @(negedge clk);
    chk("e_resp_ready", 64'(bus.resp_ready), 64'd0);
    chk("e_resp0_valid", 64'(bus.resp0_valid), 64'd0);
    chk("e_resp1_valid", 64'(bus.resp1_valid), 64'd0);
    step();
    bus.l2_resp_valid = 0;
    @(negedge clk);
    chk("e_orphan_set", 64'(bus.resp_orphan), 64'd1);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("e_orphan_clr", 64'(bus.resp_orphan), 64'd0);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.req0_valid = 1'($urandom); bus.req0_op = 2'($urandom); bus.req0_addr = 29'($urandom);
      bus.req0_wmask = 8'($urandom); bus.req0_wdata = {$urandom, $urandom};
      bus.req1_valid = 1'($urandom); bus.req1_op = 2'($urandom); bus.req1_addr = 29'($urandom);
      bus.req1_wmask = 8'($urandom); bus.req1_wdata = {$urandom, $urandom};
      bus.l2_req_ready  = ($urandom_range(0, 3) != 0);
      bus.l2_resp_valid = ($urandom_range(0, 4) < 3);
      bus.l2_resp_error = 1'($urandom); bus.l2_resp_op = 2'($urandom);
      bus.l2_resp_addr  = 26'($urandom); bus.l2_resp_rdata = {$urandom, $urandom};
      bus.resp0_ready = ($urandom_range(0, 3) != 0);
      bus.resp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
